// File: rtl/adc108s102_spi_ctrl.sv
// SPI master for the ADC108S102: sends the channel word, captures the 10-bit result.
// Define ADC_AUTO_SCAN_EN to free-run frames that cycle through all eight channels.
module adc108s102_spi_ctrl #(
   parameter int CLK_DIV   = 4,
   parameter int QUIET_CYC = 4,
   parameter int DIV_W     = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] channel,
   output logic       busy,
   output logic       data_valid,
   output logic [9:0] data,
   output logic [2:0] data_channel,
   output logic       adc_cs_n,
   output logic       adc_sclk,
   output logic       adc_din,
   input  logic       adc_dout
);

   localparam int QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [QW-1:0]    QUIET_LAST = QW'(QUIET_CYC - 1);

   typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

   state_t           state;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       bit_cnt;
   logic [QW-1:0]    quiet_cnt;
   logic [15:0]      tx;
   logic [11:0]      rx;
   logic [2:0]       cur_ch;
   logic [2:0]       prev_ch;
   logic             dout_meta;
   logic             dout_sync;

`ifdef ADC_AUTO_SCAN_EN
   logic [2:0]       scan_cnt;
   logic             unused_inputs;
   assign unused_inputs = start ^ (^channel);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_meta <= 1'b0;
         dout_sync <= 1'b0;
      end else begin
         dout_meta <= adc_dout;
         dout_sync <= dout_meta;
      end
   end

   // The result of a frame belongs to the address sent in the previous frame,
   // so prev_ch tracks what the device is currently converting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         div_cnt      <= '0;
         bit_cnt      <= '0;
         quiet_cnt    <= '0;
         tx           <= '0;
         rx           <= '0;
         cur_ch       <= '0;
         prev_ch      <= '0;
         busy         <= 1'b0;
         data_valid   <= 1'b0;
         data         <= '0;
         data_channel <= '0;
         adc_cs_n     <= 1'b1;
         adc_sclk     <= 1'b1;
         adc_din      <= 1'b0;
`ifdef ADC_AUTO_SCAN_EN
         scan_cnt     <= '0;
`endif
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
`ifdef ADC_AUTO_SCAN_EN
               cur_ch   <= scan_cnt;
               tx       <= {2'b00, scan_cnt, 11'b0};
               scan_cnt <= scan_cnt + 3'd1;
               adc_cs_n <= 1'b0;
               busy     <= 1'b1;
               div_cnt  <= '0;
               state    <= SETUP;
`else
               if (start) begin
                  cur_ch   <= channel;
                  tx       <= {2'b00, channel, 11'b0};
                  adc_cs_n <= 1'b0;
                  busy     <= 1'b1;
                  div_cnt  <= '0;
                  state    <= SETUP;
               end
`endif
            end
            SETUP: begin
               if (div_cnt == DIV_LAST) begin
                  div_cnt  <= '0;
                  bit_cnt  <= '0;
                  adc_sclk <= 1'b0;
                  adc_din  <= tx[15];
                  tx       <= {tx[14:0], 1'b0};
                  state    <= SHIFT;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            SHIFT: begin
               if (div_cnt != DIV_LAST) begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end else begin
                  div_cnt <= '0;
                  if (!adc_sclk) begin
                     adc_sclk <= 1'b1;
                     rx       <= {rx[10:0], dout_sync};
                  end else if (bit_cnt == 4'd15) begin
                     adc_cs_n  <= 1'b1;
                     adc_din   <= 1'b0;
                     quiet_cnt <= '0;
                     state     <= HOLD;
                  end else begin
                     bit_cnt  <= bit_cnt + 4'd1;
                     adc_sclk <= 1'b0;
                     adc_din  <= tx[15];
                     tx       <= {tx[14:0], 1'b0};
                  end
               end
            end
            HOLD: begin
               if (quiet_cnt == '0) begin
                  data_valid   <= 1'b1;
                  data         <= rx[11:2];
                  data_channel <= prev_ch;
                  prev_ch      <= cur_ch;
               end
               if (quiet_cnt == QUIET_LAST) begin
                  state <= IDLE;
`ifndef ADC_AUTO_SCAN_EN
                  busy  <= 1'b0;
`endif
               end else begin
                  quiet_cnt <= quiet_cnt + QW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_adc108s102_spi_ctrl.sv
// Bench for adc108s102_spi_ctrl: behavioural ADC model plus a result scoreboard.
module tb_adc108s102_spi_ctrl;

   localparam int CLK_DIV    = 4;
   localparam int QUIET_CYC  = 4;
   localparam int FRAME_CLKS = CLK_DIV + 32 * CLK_DIV + QUIET_CYC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [2:0] channel = 3'd0;
   logic       busy;
   logic       data_valid;
   logic [9:0] data;
   logic [2:0] data_channel;
   logic       adc_cs_n;
   logic       adc_sclk;
   logic       adc_din;
   logic       adc_dout = 1'b0;

   typedef struct {
      logic [9:0] data;
      logic [2:0] ch;
   } exp_t;

   typedef struct {
      logic [2:0] ch;
      logic [9:0] adc_val;
      logic [2:0] exp_ch;
   } vec_t;

   exp_t       sb_q[$];
   exp_t       sb_e;
   vec_t       vecs[5];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         dv_count = 0;
   int         dv_cyc = 0;
   int         t0 = 0;
   int         falls = 0;
   int         lat;
   int         n0;
   int         cs_low;
   int         busy_hi;
   logic [15:0] sr = '0;
   logic [15:0] din_word = '0;
   logic [9:0]  next_val = '0;
   logic [2:0]  exp_prev = '0;
   logic [2:0]  saved_prev;

   adc108s102_spi_ctrl #(
      .CLK_DIV(CLK_DIV),
      .QUIET_CYC(QUIET_CYC),
      .DIV_W(3)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .channel(channel),
      .busy(busy),
      .data_valid(data_valid),
      .data(data),
      .data_channel(data_channel),
      .adc_cs_n(adc_cs_n),
      .adc_sclk(adc_sclk),
      .adc_din(adc_din),
      .adc_dout(adc_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Device model: a frame returns {4'b0, value, 2'b0}, one bit per SCLK fall.
   always @(negedge adc_cs_n) begin
      sr       = {4'b0000, next_val, 2'b00};
      falls    = 0;
      din_word = '0;
   end

   always @(negedge adc_sclk) begin
      if (!adc_cs_n) begin
         adc_dout = sr[15];
         sr       = {sr[14:0], 1'b0};
         falls++;
      end
   end

   always @(posedge adc_sclk) begin
      if (!adc_cs_n) din_word = {din_word[14:0], adc_din};
   end

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && data_valid) begin
         dv_count++;
         dv_cyc = cyc;
`ifndef ADC_AUTO_SCAN_EN
         if (sb_q.size() == 0) begin
            check_output("unexpected_data_valid", 1, 0);
         end else begin
            sb_e = sb_q.pop_front();
            check_output("sb_data", int'(data), int'(sb_e.data));
            check_output("sb_channel", int'(data_channel), int'(sb_e.ch));
         end
`endif
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      sb_q.delete();
      exp_prev = '0;
   endtask

   task automatic apply_stimulus(input logic [2:0] ch, input logic [9:0] val);
      @(negedge clk);
      next_val = val;
      channel  = ch;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
      sb_q.push_back('{data: val, ch: exp_prev});
      exp_prev = ch;
   endtask

   task automatic wait_idle(output int latency);
      latency = -1;
      for (int i = 0; i < FRAME_CLKS + 50; i++) begin
         @(negedge clk);
         if (!busy) begin
            latency = cyc - t0;
            break;
         end
      end
      if (latency < 0) check_output("idle_timeout", 0, 1);
   endtask

   initial begin
`ifdef ADC_AUTO_SCAN_EN
      int exp_seq[9] = '{0, 0, 1, 2, 3, 4, 5, 6, 7};
      int seen = 0;
      do_reset();
      check_output("auto_reset_channel", int'(data_channel), 0);
      for (int i = 0; i < 9 * (FRAME_CLKS + 2) + 100 && seen < 9; i++) begin
         @(negedge clk);
         if (i > 2) begin
            if (!busy) check_output("auto_busy", 0, 1);
         end
         if (data_valid) begin
            check_output($sformatf("auto_channel_%0d", seen), int'(data_channel), exp_seq[seen]);
            seen++;
         end
      end
      check_output("auto_frame_count", seen, 9);
`else
      vecs[0] = '{ch: 3'd5, adc_val: 10'h155, exp_ch: 3'd0};
      vecs[1] = '{ch: 3'd2, adc_val: 10'h3FF, exp_ch: 3'd5};
      vecs[2] = '{ch: 3'd7, adc_val: 10'h000, exp_ch: 3'd2};
      vecs[3] = '{ch: 3'd3, adc_val: 10'h2A5, exp_ch: 3'd7};
      vecs[4] = '{ch: 3'd0, adc_val: 10'h1C3, exp_ch: 3'd3};

      do_reset();
      check_output("rst_cs_n", int'(adc_cs_n), 1);
      check_output("rst_sclk", int'(adc_sclk), 1);
      check_output("rst_din", int'(adc_din), 0);
      check_output("rst_busy", int'(busy), 0);
      check_output("rst_data_valid", int'(data_valid), 0);
      check_output("rst_data", int'(data), 0);
      check_output("rst_data_channel", int'(data_channel), 0);
      n0 = dv_count;
      cs_low = 0;
      busy_hi = 0;
      repeat (500) begin
         @(negedge clk);
         if (!adc_cs_n) cs_low++;
         if (busy) busy_hi++;
      end
      check_output("idle_cs_low_cycles", cs_low, 0);
      check_output("idle_busy_cycles", busy_hi, 0);
      check_output("idle_data_valid_count", dv_count - n0, 0);

      // Single frame with timing of data_valid and busy release.
      apply_stimulus(3'd3, 10'h2A5);
      wait_idle(lat);
      check_output("frame_busy_latency", lat, FRAME_CLKS);
      check_output("frame_dv_latency", dv_cyc - t0, 133);
      check_output("frame_sclk_falls", falls, 16);
      check_output("frame_din_word", int'(din_word), 16'h1800);
      check_output("frame_sclk_idle", int'(adc_sclk), 1);
      check_output("frame_cs_idle", int'(adc_cs_n), 1);

      do_reset();
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(vecs[i].ch, vecs[i].adc_val);
         wait_idle(lat);
         check_output($sformatf("tbl%0d_busy_latency", i), lat, FRAME_CLKS);
         check_output($sformatf("tbl%0d_data_channel", i), int'(data_channel), int'(vecs[i].exp_ch));
         check_output($sformatf("tbl%0d_data", i), int'(data), int'(vecs[i].adc_val));
         check_output($sformatf("tbl%0d_din_word", i), int'(din_word), int'({2'b00, vecs[i].ch, 11'b0}));
      end

      // A start pulse mid-frame and a channel change must both be ignored.
      n0 = dv_count;
      saved_prev = exp_prev;
      apply_stimulus(3'd4, 10'h0F0);
      repeat (38) @(negedge clk);
      channel = 3'd1;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      channel = 3'd7;
      wait_idle(lat);
      repeat (10) @(negedge clk);
      check_output("busy_start_dv_count", dv_count - n0, 1);
      check_output("busy_start_idle", int'(busy), 0);
      check_output("busy_start_channel", int'(data_channel), int'(saved_prev));
      check_output("busy_start_din_word", int'(din_word), 16'h2000);

      // Reset in the middle of bit 8.
      apply_stimulus(3'd6, 10'h155);
      lat = -1;
      for (int i = 0; i < FRAME_CLKS; i++) begin
         @(negedge clk);
         if (falls >= 9) begin
            lat = i;
            break;
         end
      end
      if (lat < 0) check_output("bit8_timeout", 0, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("midrst_cs_high", int'(adc_cs_n), 1);
      check_output("midrst_sclk_high", int'(adc_sclk), 1);
      check_output("midrst_busy_low", int'(busy), 0);
      sb_q.delete();
      exp_prev = '0;
      n0 = dv_count;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_output("midrst_no_dv", dv_count - n0, 0);
      apply_stimulus(3'd1, 10'h3C3);
      wait_idle(lat);
      check_output("midrst_next_channel", int'(data_channel), 0);
      check_output("midrst_next_data", int'(data), 10'h3C3);

      repeat (5) @(negedge clk);
      check_output("sb_drained", sb_q.size(), 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
